// File: rtl/data_path_more_if.sv
// Bus between the datapath and its surroundings: instruction field and control
// inputs from the control unit / memories, datapath results back out.
interface data_path_more_if;
  logic [25:0] inst_field;
  logic        Jal;
  logic        RegDst;
  logic [31:0] Data_in;
  logic [1:0]  DatatoReg;
  logic [2:0]  ALU_Control;
  logic [1:0]  Branch;
  logic        ALUSrc_B;
  logic        RegWrite;
  logic [31:0] PC_out;
  logic [31:0] pc_4;
  logic [31:0] ALU_out;
  logic [31:0] Data_out;
  logic        zero;
  logic        overflow;

  modport master (
    output inst_field, Jal, RegDst, Data_in, DatatoReg, ALU_Control, Branch,
           ALUSrc_B, RegWrite,
    input  PC_out, pc_4, ALU_out, Data_out, zero, overflow
  );

  modport slave (
    input  inst_field, Jal, RegDst, Data_in, DatatoReg, ALU_Control, Branch,
           ALUSrc_B, RegWrite,
    output PC_out, pc_4, ALU_out, Data_out, zero, overflow
  );
endinterface

// File: rtl/data_path_more.sv
// Single-cycle MIPS-style datapath: PC, 32x32 register file, ALU, immediate
// extension, write-back and next-PC selection. One instruction per clock.
module data_path_more (
  input  logic            clk,
  input  logic            rst,
  data_path_more_if.slave bus
);
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];

  logic [4:0]  rs, rt, rd, waddr;
  logic [15:0] imm;
  logic [31:0] imm_ext, rdata_a, rdata_b, alu_b, alu_res, wdata, pc_4;
  logic        alu_ovf;
  alu_op_e     alu_op;

  assign rs      = bus.inst_field[25:21];
  assign rt      = bus.inst_field[20:16];
  assign rd      = bus.inst_field[15:11];
  assign imm     = bus.inst_field[15:0];
  assign imm_ext = {{16{imm[15]}}, imm};
  assign alu_op  = alu_op_e'(bus.ALU_Control);
  assign pc_4    = pc_q + 32'd4;

  // r0 is never written, but the explicit guard keeps it zero by construction.
  assign rdata_a = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rdata_b = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign alu_b   = bus.ALUSrc_B ? imm_ext : rdata_b;
  assign waddr   = bus.Jal ? 5'd31 : (bus.RegDst ? rd : rt);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = 32'd0;
    alu_ovf = 1'b0;
    unique case (alu_op)
      ALU_AND: alu_res = rdata_a & alu_b;
      ALU_OR:  alu_res = rdata_a | alu_b;
      ALU_XOR: alu_res = rdata_a ^ alu_b;
      ALU_NOR: alu_res = ~(rdata_a | alu_b);
      ALU_SRL: alu_res = alu_b >> rdata_a[4:0];
      ALU_SLT: alu_res = {31'd0, rdata_a < alu_b};
      ALU_ADD: begin
        alu_res = rdata_a + alu_b;
        alu_ovf = (rdata_a[31] == alu_b[31]) && (alu_res[31] != rdata_a[31]);
      end
      ALU_SUB: begin
        alu_res = rdata_a - alu_b;
        alu_ovf = (rdata_a[31] != alu_b[31]) && (alu_res[31] != rdata_a[31]);
      end
    endcase
  end

  always_comb begin
    wdata = alu_res;
    unique case (bus.DatatoReg)
      2'b00: wdata = alu_res;
      2'b01: wdata = bus.Data_in;
      2'b10: wdata = {imm, 16'h0000};
      2'b11: wdata = pc_4;
    endcase
  end

  always_comb begin
    pc_d = pc_4;
    unique case (bus.Branch)
      2'b00: pc_d = pc_4;
      2'b01: pc_d = (alu_res == 32'd0) ? pc_4 + {imm_ext[29:0], 2'b00} : pc_4;
      2'b10: pc_d = {pc_4[31:28], bus.inst_field, 2'b00};
      2'b11: pc_d = rdata_a;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; JR/JAL and same-cycle reads depend on that.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= 32'd0;
      // NOTE: the register file is cleared on reset because software relies on
      // all registers starting at zero; this forces flops rather than a RAM macro.
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (bus.RegWrite && (waddr != 5'd0)) rf_q[waddr] <= wdata;
    end
  end

  assign bus.PC_out   = pc_q;
  assign bus.pc_4     = pc_4;
  assign bus.ALU_out  = alu_res;
  assign bus.Data_out = rdata_b;
  assign bus.zero     = (alu_res == 32'd0);
  assign bus.overflow = alu_ovf;
endmodule

// File: tb/tb_data_path_more.sv
// Self-checking bench for data_path_more: directed program fragments plus
// randomized instructions against an architectural model of registers and PC.
module tb_data_path_more;
  typedef struct packed {
    logic       jal;
    logic       regdst;
    logic [1:0] dtr;
    logic [2:0] aluc;
    logic [1:0] br;
    logic       srcb;
    logic       rw;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  data_path_more_if bus();
  data_path_more dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_pc;
  logic [31:0] nx_pc, nx_wdata;
  logic [4:0]  nx_waddr;
  logic        nx_we, nx_rst;
  logic [31:0] pc_snap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t ctl(input logic jal, input logic regdst, input logic [1:0] dtr,
                                input logic [2:0] op, input logic [1:0] br,
                                input logic srcb, input logic rw);
    ctl = {jal, regdst, dtr, op, br, srcb, rw};
  endfunction

  function automatic logic [25:0] r_fmt(input int rs, input int rt, input int rd);
    r_fmt = {rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [25:0] i_fmt(input int rs, input int rt, input logic [15:0] imm);
    i_fmt = {rs[4:0], rt[4:0], imm};
  endfunction

  // Reference ALU from the architectural definition; overflow is judged by
  // whether the exact signed result leaves the 32-bit range.
  function automatic void alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ovf);
    longint s;
    ovf = 1'b0;
    r   = 32'd0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b011: r = a ^ b;
      3'b100: r = ~(a | b);
      3'b101: r = b >> (a % 32);
      3'b111: r = (a < b) ? 32'd1 : 32'd0;
      3'b010: begin
        s   = longint'($signed(a)) + longint'($signed(b));
        r   = a + b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        s   = longint'($signed(a)) - longint'($signed(b));
        r   = a - b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: r = 32'd0;
    endcase
  endfunction

  // Drive one instruction, check combinational outputs, and compute the
  // architectural effect to be committed at the next edge.
  task automatic apply(input logic [25:0] inst, input ctrl_t c, input logic [31:0] din,
                       input logic do_rst);
    logic [31:0] a, b, bop, sext, res, pc4;
    logic        ovf;
    rst             = do_rst;
    bus.inst_field  = inst;
    bus.Jal         = c.jal;
    bus.RegDst      = c.regdst;
    bus.DatatoReg   = c.dtr;
    bus.ALU_Control = c.aluc;
    bus.Branch      = c.br;
    bus.ALUSrc_B    = c.srcb;
    bus.RegWrite    = c.rw;
    bus.Data_in     = din;
    #1;
    a    = m_reg[inst[25:21]];
    b    = m_reg[inst[20:16]];
    sext = 32'($signed(inst[15:0]));
    bop  = c.srcb ? sext : b;
    alu_ref(c.aluc, a, bop, res, ovf);
    pc4  = m_pc + 32'd4;
    check("pc_out", bus.PC_out, m_pc);
    check("pc_4", bus.pc_4, pc4);
    check("alu_out", bus.ALU_out, res);
    check("zero", 32'(bus.zero), (res == 32'd0) ? 32'd1 : 32'd0);
    check("overflow", 32'(bus.overflow), 32'(ovf));
    check("data_out", bus.Data_out, b);
    case (c.br)
      2'b00:   nx_pc = pc4;
      2'b01:   nx_pc = (res == 32'd0) ? pc4 + sext * 4 : pc4;
      2'b10:   nx_pc = (pc4 & 32'hF000_0000) | (32'(inst) << 2);
      default: nx_pc = a;
    endcase
    case (c.dtr)
      2'b00:   nx_wdata = res;
      2'b01:   nx_wdata = din;
      2'b10:   nx_wdata = 32'(inst[15:0]) * 65536;
      default: nx_wdata = pc4;
    endcase
    nx_waddr = c.jal ? 5'd31 : (c.regdst ? inst[15:11] : inst[20:16]);
    nx_we    = c.rw;
    nx_rst   = do_rst;
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    if (nx_rst) begin
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    end else begin
      m_pc = nx_pc;
      if (nx_we && nx_waddr != 5'd0) m_reg[nx_waddr] = nx_wdata;
    end
  endtask

  task automatic read_reg(input int idx, input logic [31:0] exp, input string tag);
    bus.inst_field = {5'd0, idx[4:0], 16'd0};
    bus.RegWrite   = 1'b0;
    #1;
    check(tag, bus.Data_out, exp);
  endtask

  ctrl_t nop_c, add_c, beq_c, j_c;

  initial begin
    nop_c = ctl(1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    add_c = ctl(1'b0, 1'b1, 2'b00, 3'b010, 2'b00, 1'b0, 1'b1);
    beq_c = ctl(1'b0, 1'b0, 2'b00, 3'b110, 2'b01, 1'b0, 1'b0);
    j_c   = ctl(1'b0, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0, 1'b0);

    // Reset held for two edges.
    rst = 1'b1;
    bus.inst_field = '0; bus.Jal = 1'b0; bus.RegDst = 1'b0; bus.DatatoReg = 2'b00;
    bus.ALU_Control = 3'b000; bus.Branch = 2'b00; bus.ALUSrc_B = 1'b0;
    bus.RegWrite = 1'b0; bus.Data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    check("rst_pc", bus.PC_out, 32'd0);
    check("rst_pc4", bus.pc_4, 32'd4);
    for (int i = 0; i < 32; i++) read_reg(i, 32'd0, $sformatf("rst_r%0d", i));
    rst = 1'b0;

    apply(26'd0, nop_c, 32'd0, 1'b0); commit();
    apply(26'd0, nop_c, 32'd0, 1'b0); commit();
    check("pc_advance", bus.PC_out, 32'd8);

    // NOR r1,r0,r0 then SLT r2,r0,r1 (unsigned).
    apply(r_fmt(0, 0, 1), ctl(1'b0, 1'b1, 2'b00, 3'b100, 2'b00, 1'b0, 1'b1), 32'd0, 1'b0); commit();
    read_reg(1, 32'hFFFF_FFFF, "nor_r1");
    apply(r_fmt(0, 1, 2), ctl(1'b0, 1'b1, 2'b00, 3'b111, 2'b00, 1'b0, 1'b1), 32'd0, 1'b0); commit();
    read_reg(2, 32'd1, "slt_r2");

    // Fibonacci chain r3..r31.
    for (int n = 3; n < 32; n++) begin
      apply(r_fmt(n - 1, (n == 3) ? 2 : n - 2, n), add_c, 32'd0, 1'b0);
      check("fib_zero", 32'(bus.zero), 32'd0);
      check("fib_ovf", 32'(bus.overflow), 32'd0);
      commit();
    end
    read_reg(3, 32'd2, "fib_r3");
    read_reg(4, 32'd3, "fib_r4");
    read_reg(10, 32'd55, "fib_r10");
    read_reg(20, 32'd6765, "fib_r20");
    read_reg(31, 32'd1346269, "fib_r31");

    // Restore r2 = 1, then r6 = 0xFFFFFFFF >> 1.
    apply(i_fmt(0, 2, 16'h0001), ctl(1'b0, 1'b0, 2'b00, 3'b001, 2'b00, 1'b1, 1'b1), 32'd0, 1'b0); commit();
    apply(r_fmt(2, 1, 6), ctl(1'b0, 1'b1, 2'b00, 3'b101, 2'b00, 1'b0, 1'b1), 32'd0, 1'b0); commit();
    read_reg(6, 32'h7FFF_FFFF, "srl_r6");
    // ADD r6 + 1 with immediate; rd field is 0 so the write targets r0.
    apply(i_fmt(6, 0, 16'h0001), ctl(1'b0, 1'b1, 2'b00, 3'b010, 2'b00, 1'b1, 1'b1), 32'd0, 1'b0);
    check("ovf_alu", bus.ALU_out, 32'h8000_0000);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    commit();
    read_reg(0, 32'd0, "r0_kept");

    // Branches.
    pc_snap = bus.PC_out;
    apply(i_fmt(2, 2, 16'h0003), beq_c, 32'd0, 1'b0);
    check("beq_zero", 32'(bus.zero), 32'd1);
    commit();
    check("beq_taken", bus.PC_out, pc_snap + 32'd16);
    pc_snap = bus.PC_out;
    apply(i_fmt(2, 3, 16'h0003), beq_c, 32'd0, 1'b0); commit();
    check("beq_not_taken", bus.PC_out, pc_snap + 32'd4);
    apply(26'h000_0010, j_c, 32'd0, 1'b0); commit();
    check("jump", bus.PC_out, 32'h0000_0040);

    // Link and return.
    apply(26'h000_0008, j_c, 32'd0, 1'b0); commit();
    check("jump_20", bus.PC_out, 32'h0000_0020);
    apply(26'h000_0030, ctl(1'b1, 1'b0, 2'b11, 3'b000, 2'b10, 1'b0, 1'b1), 32'd0, 1'b0); commit();
    check("jal_pc", bus.PC_out, 32'h0000_00C0);
    read_reg(31, 32'h0000_0024, "jal_r31");
    apply({5'd31, 21'd0}, ctl(1'b0, 1'b0, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0), 32'd0, 1'b0); commit();
    check("jr_pc", bus.PC_out, 32'h0000_0024);

    // LUI r7 and load write-back into r8.
    apply(i_fmt(0, 7, 16'h1234), ctl(1'b0, 1'b0, 2'b10, 3'b000, 2'b00, 1'b1, 1'b1), 32'd0, 1'b0); commit();
    read_reg(7, 32'h1234_0000, "lui_r7");
    apply(i_fmt(0, 8, 16'h0000), ctl(1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b1, 1'b1), 32'hCAFE_F00D, 1'b0); commit();
    read_reg(8, 32'hCAFE_F00D, "load_r8");

    // Reset overrides a pending write and jump.
    apply(r_fmt(1, 1, 9), ctl(1'b0, 1'b1, 2'b00, 3'b010, 2'b10, 1'b0, 1'b1), 32'd0, 1'b1); commit();
    check("midrst_pc", bus.PC_out, 32'd0);
    read_reg(9, 32'd0, "midrst_r9");
    read_reg(7, 32'd0, "midrst_r7");

    // Seed registers with random values, then random instructions.
    for (int i = 1; i < 32; i++) begin
      apply(i_fmt(0, i, 16'h0000), ctl(1'b0, 1'b0, 2'b01, 3'b000, 2'b00, 1'b1, 1'b1), $urandom, 1'b0);
      commit();
    end
    for (int k = 0; k < 600; k++) begin
      apply(26'($urandom), ctrl_t'($urandom), $urandom, ($urandom_range(0, 79) == 0));
      commit();
      if (k % 8 == 0) begin
        int idx;
        idx = $urandom_range(0, 31);
        read_reg(idx, m_reg[idx], "rand_reg");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
